// File: rtl/trap_ctrl.sv
// Trap/mret sequencer: accepts one exception, mret or timer interrupt at a time,
// flushes for DRAIN_CYCLES, pulses the CSR commit, then redirects fetch.
module trap_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_val,
  input  logic        mret_req,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  input  logic        timer_interrupt,
  input  logic        mie_mtie,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        trap_enter,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic [31:0] trap_val,
  output logic        mret_exec,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_e;
  typedef enum logic {TRAP, MRET} kind_e;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tpc_q, tpc_d;
  logic [31:0] tval_q, tval_d;
  logic        irq_eligible;

  assign irq_eligible = timer_interrupt & mie_mtie & mstatus_mie & next_pc_valid;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    tpc_d   = tpc_q;
    tval_d  = tval_q;
    case (state_q)
      IDLE: begin
        // Lower-priority requests in the same cycle are dropped, not queued.
        if (exc_valid) begin
          state_d = DRAIN;
          kind_d  = TRAP;
          cnt_d   = DRAIN_LOAD;
          cause_d = {28'b0, exc_code};
          tpc_d   = exc_pc;
          tval_d  = exc_val;
        end else if (mret_req) begin
          state_d = DRAIN;
          kind_d  = MRET;
          cnt_d   = DRAIN_LOAD;
        end else if (irq_eligible) begin
          state_d = DRAIN;
          kind_d  = TRAP;
          cnt_d   = DRAIN_LOAD;
          cause_d = 32'h8000_0007;
          tpc_d   = next_pc;
          tval_d  = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == 4'd0) state_d = COMMIT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      COMMIT:   state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= TRAP;
      cnt_q   <= '0;
      cause_q <= '0;
      tpc_q   <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      tpc_q   <= tpc_d;
      tval_q  <= tval_d;
    end
  end

  // Outputs are decoded from state so an async reset kills any pending pulse at once.
  always_comb begin
    flush          = (state_q == DRAIN);
    busy           = (state_q != IDLE);
    trap_enter     = (state_q == COMMIT) && (kind_q == TRAP);
    mret_exec      = (state_q == COMMIT) && (kind_q == MRET);
    redirect_valid = (state_q == REDIRECT);
    redirect_pc    = '0;
    if (state_q == REDIRECT) redirect_pc = (kind_q == TRAP) ? mtvec : mepc;
  end

  assign trap_cause = cause_q;
  assign trap_pc    = tpc_q;
  assign trap_val   = tval_q;

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap and return sequencer for the M-mode core. It sits between the pipeline's commit point and the CSR register file. It takes in synchronous exceptions, `mret` requests and the timer interrupt, then flushes the pipeline and drains in-flight work. Once drained, it issues one `trap_enter` or `mret_exec` pulse to the CSR file and redirects fetch to `mtvec` or `mepc`. It drives the trap side of the CSR interface and consumes the CSR file's vector, return address and interrupt-enable outputs.

## Interface
- DRAIN_CYCLES, 2: cycles the pipeline is held in flush after acceptance, before the CSR commit. Legal range is 1..15.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- exc_valid  in  1  synchronous exception at the commit point
- exc_code  in  4  exception code (for example 2 for illegal instruction, 11 for ecall-M)
- exc_pc  in  32  PC of the faulting instruction
- exc_val  in  32  faulting address or instruction bits
- mret_req  in  1  an `mret` has reached the commit point
- next_pc  in  32  PC of the next instruction to retire
- next_pc_valid  in  1  `next_pc` is meaningful
- timer_interrupt  in  1  level timer interrupt
- mie_mtie  in  1  timer interrupt enable from the CSR file
- mstatus_mie  in  1  global interrupt enable from the CSR file
- mtvec  in  32  trap vector from the CSR file (direct mode, bits [1:0] always 0)
- mepc  in  32  return address from the CSR file
- trap_enter  out  1  one-cycle pulse to the CSR file
- trap_cause  out  32  mcause value
- trap_pc  out  32  mepc value
- trap_val  out  32  mtval value
- mret_exec  out  1  one-cycle pulse to the CSR file
- flush  out  1  kill all uncommitted instructions and hold fetch
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target
- busy  out  1  sequencer is not in IDLE

## Operation
- States and transitions:
  - IDLE goes to DRAIN on acceptance.
  - DRAIN counts down `DRAIN_CYCLES` cycles, then goes to COMMIT.
  - COMMIT lasts one cycle, then goes to REDIRECT.
  - REDIRECT lasts one cycle, then goes to IDLE.
- Acceptance happens only in IDLE. Priority order:
  1. `exc_valid` (kind TRAP): capture `trap_cause = {28'b0, exc_code}`, `trap_pc = exc_pc`, `trap_val = exc_val`.
  2. `mret_req` (kind MRET): capture nothing into the trap registers.
  3. Interrupt, when `timer_interrupt & mie_mtie & mstatus_mie & next_pc_valid` (kind TRAP): capture `trap_cause = 32'h8000_0007`, `trap_pc = next_pc`, `trap_val = 0`.
- The lower-priority request on a simultaneous event is dropped, not queued. The pipeline re-presents a dropped `mret`; an interrupt is still pending on its level.
- While `busy`, all request inputs are ignored.
- State-decoded outputs:
  - `flush` = (state == DRAIN)
  - `busy` = (state != IDLE)
  - `trap_enter` = (COMMIT & kind == TRAP)
  - `mret_exec` = (COMMIT & kind == MRET)
  - `redirect_valid` = (state == REDIRECT)
- `redirect_pc` is `mtvec` for kind TRAP and `mepc` for kind MRET, sampled combinationally during REDIRECT. The CSR file has already updated by then. It is 0 outside REDIRECT.
- `trap_cause`, `trap_pc` and `trap_val` are registers. They hold their captured values from acceptance until the next TRAP acceptance. An MRET acceptance leaves them unchanged.
- The drain counter is 4 bits. It loads `DRAIN_CYCLES - 1` on acceptance, decrements in DRAIN and leaves DRAIN at 0. It has no wrap-around.
- No re-trigger loop: after COMMIT the CSR file clears `mstatus_mie`, so a still-high `timer_interrupt` is not re-accepted in the IDLE cycle after REDIRECT.

## Timing
- Reset value of every output is 0. The state is IDLE and kind is TRAP.
- Acceptance is at clock edge E0 (request visible in the cycle before E0).
- `flush` is high for cycles 1..D after E0, where D = `DRAIN_CYCLES`.
- `trap_enter` or `mret_exec` is high in cycle D+1.
- `redirect_valid` is high in cycle D+2.
- IDLE resumes in cycle D+3; a new request may be accepted at the edge that ends cycle D+3.
- Minimum spacing between accepted events is D+3 cycles.
- Reset asserted in any state returns the block to IDLE and clears every output in the same cycle (asynchronous). No partial CSR pulse may follow.

## Test plan
- Reset: assert `rst` during DRAIN -> `flush`, `busy` and all pulses drop to 0 immediately; after release, no `trap_enter` appears.
- Ecall (D=2): `exc_valid=1`, `exc_code=11`, `exc_pc=0x100`, `mtvec=0x80` -> `flush` high in cycles 1-2; `trap_enter` high in cycle 3 with `trap_cause=0xB`, `trap_pc=0x100`; `redirect_pc=0x80` in cycle 4.
- Timer gating: `timer_interrupt=1`, `mie_mtie=1`, `mstatus_mie=0` -> no acceptance. Raise `mstatus_mie` with `next_pc=0x204` -> `trap_cause=0x80000007`, `trap_pc=0x204`, `trap_val=0`.
- Priority: `exc_valid` (code 2, val `0xDEAD`), `mret_req` and an eligible interrupt in the same cycle -> only TRAP, `trap_cause=2`, `trap_val=0xDEAD`; `mret_exec` never pulses.
- Mret: `mret_req=1`, `mepc=0x300` -> `mret_exec` high in cycle 3, `redirect_pc=0x300` in cycle 4, trap outputs unchanged.
- Busy ignore: a second `exc_valid` during DRAIN -> no effect; exactly one `trap_enter` for the sequence.
